nibble_serial_adder: RTL and testbench



---
 rtl/nibble_serial_adder.sv | 144 ++++++++++++++
 tb/tb_nibble_serial_adder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: wide-operand adder that pushes one nibble per cycle, LSB first, through an
// external combinational 4-bit adder stage. The carry between nibbles is registered.
//
// Optional feature: define SERIAL_ADD_OVF_EN to add the 'ovf' output (two's-complement overflow).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake (a, b, cin)
//   out_valid/out_ready   result handshake (sum, cout [, ovf])
//   add_a/add_b/add_cin   to adder stage: current nibbles and registered carry (0 outside RUN)
//   add_sum/add_cout      from adder stage: combinational nibble sum and carry
module nibble_serial_adder #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
`ifdef SERIAL_ADD_OVF_EN
  output logic                 ovf,
`endif
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [3:0]           add_sum,
  input  logic                 add_cout
);

  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned CntW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(NIBBLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_sh_q, a_sh_d;
  logic [W-1:0]    b_sh_q, b_sh_d;
  logic [W-1:0]    sum_q, sum_d;
  logic [W-1:0]    sum_shift;
  logic            cout_q, cout_d;
  logic            carry_q, carry_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // New nibble sum enters at the top; after NIBBLES shifts nibble 0 sits at the bottom.
  if (NIBBLES == 1) begin : g_one
    assign sum_shift = add_sum;
  end else begin : g_many
    assign sum_shift = {add_sum, sum_q[W-1:4]};
  end

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q, ovf_d;
  assign ovf = ovf_q;
`endif

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    add_a   = 4'h0;
    add_b   = 4'h0;
    add_cin = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        add_a   = a_sh_q[3:0];
        add_b   = b_sh_q[3:0];
        add_cin = carry_q;
        carry_d = add_cout;
        sum_d   = sum_shift;
        a_sh_d  = a_sh_q >> 4;
        b_sh_d  = b_sh_q >> 4;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          cout_d  = add_cout;
          state_d = StHold;
`ifdef SERIAL_ADD_OVF_EN
          // Low nibbles now hold the operand MSB nibbles; add_sum[3] is the result MSB.
          ovf_d = (a_sh_q[3] == b_sh_q[3]) && (add_sum[3] != a_sh_q[3]);
`endif
        end
      end
      StHold: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end
`endif

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StHold);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance, NIBBLES=4
  logic         in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0;
  logic         in_ready, out_valid, cout;
  logic [W-1:0] a = '0, b = '0, sum;
  logic [3:0]   add_a, add_b, add_sum;
  logic         add_cin, add_cout;
  logic         ovf;

  // Secondary instance, NIBBLES=1
  logic         in_valid1 = 1'b0, cin1 = 1'b0;
  logic         out_ready1 = 1'b1;
  logic         in_ready1, out_valid1, cout1;
  logic [3:0]   a1 = '0, b1 = '0, sum1;
  logic [3:0]   add_a1, add_b1, add_sum1;
  logic         add_cin1, add_cout1;
  logic         ovf1;

  // External 4-bit adder stages
  assign {add_cout, add_sum}   = 5'(add_a) + 5'(add_b) + 5'(add_cin);
  assign {add_cout1, add_sum1} = 5'(add_a1) + 5'(add_b1) + 5'(add_cin1);

`ifndef SERIAL_ADD_OVF_EN
  assign ovf  = 1'b0;
  assign ovf1 = 1'b0;
`endif

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
`ifdef SERIAL_ADD_OVF_EN
    .ovf(ovf),
`endif
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout)
  );

  nibble_serial_adder #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
    .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1), .cout(cout1),
`ifdef SERIAL_ADD_OVF_EN
    .ovf(ovf1),
`endif
    .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1), .add_sum(add_sum1),
    .add_cout(add_cout1)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference model: plain arithmetic on the full operands.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, y, input logic c);
    ref_add = {1'b0, x} + {1'b0, y} + (W+1)'(c);
  endfunction

  // Carry into nibble i = bit 4i of the sum of the operands' low 4i bits plus cin.
  function automatic logic [N-1:0] ref_cseq(input logic [W-1:0] x, y, input logic c);
    longint unsigned m, s;
    ref_cseq = '0;
    for (int i = 0; i < N; i++) begin
      m = (64'd1 << (4 * i)) - 64'd1;
      s = (64'(x) & m) + (64'(y) & m) + 64'(c);
      ref_cseq[i] = s[4*i];
    end
  endfunction

  // Signed overflow: true result outside the W-bit two's-complement range.
  function automatic logic ref_ovf(input logic [W-1:0] x, y, input logic c);
    longint sx, sy, r, lim;
    lim = longint'(1) << (W - 1);
    sx = longint'({1'b0, x});
    sy = longint'({1'b0, y});
    if (x[W-1]) sx = sx - (longint'(1) << W);
    if (y[W-1]) sy = sy - (longint'(1) << W);
    r = sx + sy + longint'({1'b0, c});
    ref_ovf = (r > lim - 1) || (r < -lim);
  endfunction

  // One transaction on the main instance, with 'hold' backpressure cycles in HOLD.
  task automatic do_op(input logic [W-1:0] ta, tb, input logic tc, input int hold,
                       output logic [W-1:0] rs, output logic rc, output logic ro,
                       output logic [N-1:0] cseq);
    int k;
    cseq = '0;
    @(negedge clk);
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
    // This negedge is cycle 0; the accept happens at the next rising edge.
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    k = 1;
    while (!out_valid && k < 100) begin
      if (k <= N) cseq[k-1] = add_cin;
      @(negedge clk);
      k++;
    end
    chk("latency", 64'(k), 64'(N + 1));
    chk("add_zero_in_hold", {add_a, add_b, add_cin}, 64'd0);
    rs = sum; rc = cout; ro = ovf;
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      a = ~ta; b = ~tb;
      @(negedge clk);
      chk("hold_sum_stable", 64'(sum), 64'(rs));
      chk("hold_cout_stable", 64'(cout), 64'(rc));
      chk("hold_busy", {in_ready, out_valid}, 64'b01);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_handshake", {in_ready, out_valid}, 64'b10);
  endtask

  typedef struct {
    logic [W-1:0] a, b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
    logic [N-1:0] exp_cseq;  // bit i = add_cin in RUN cycle i
  } vec_t;

  initial begin
    vec_t         vecs[6];
    logic [W-1:0] rs;
    logic         rc, ro;
    logic [N-1:0] cs;
    logic [W:0]   full;
    logic [W-1:0] ra, rb;
    logic         rcin;
    int           acc_cyc[2];
    logic [W-1:0] b2b_s[2];
    logic         b2b_c[2];
    logic [3:0]   b1_s[2];
    logic         b1_c[2];
    int           nacc, nres;
    logic         acc;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 4'b1110};
    vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 4'b0001};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 4'b1110};
    vecs[3] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1, 4'b0000};
    vecs[4] = '{16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0, 4'b1110};
    vecs[5] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 4'b0000};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready_valid", {in_ready, out_valid}, 64'b10);
    chk("rst_sum_cout", {sum, cout}, 64'd0);
    chk("rst_add_outs", {add_a, add_b, add_cin}, 64'd0);
    rst_n = 1'b1;

    // Directed table
    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, 0, rs, rc, ro, cs);
      chk($sformatf("vec%0d_sum", i), 64'(rs), 64'(vecs[i].exp_sum));
      chk($sformatf("vec%0d_cout", i), 64'(rc), 64'(vecs[i].exp_cout));
      chk($sformatf("vec%0d_cseq", i), 64'(cs), 64'(vecs[i].exp_cseq));
`ifdef SERIAL_ADD_OVF_EN
      chk($sformatf("vec%0d_ovf", i), 64'(ro), 64'(vecs[i].exp_ovf));
`endif
    end

    // Backpressure: 6 stalled HOLD cycles with pulsed in_valid
    do_op(16'hABCD, 16'h1111, 1'b0, 6, rs, rc, ro, cs);
    chk("bp_sum", 64'(rs), 64'h0000BCDE);
    chk("bp_cout", 64'(rc), 64'd0);

    // Reset after two RUN cycles
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; cin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_state", {in_ready, out_valid}, 64'b10);
    chk("midrst_sum", {sum, cout}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    chk("midrst_no_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_release", {in_ready, out_valid, sum}, {2'b10, 16'h0000});
    do_op(16'h00FF, 16'h0001, 1'b0, 0, rs, rc, ro, cs);
    chk("after_rst_sum", 64'(rs), 64'h00000100);
    chk("after_rst_cout", 64'(rc), 64'd0);

    // Randomized against the reference model
    for (int t = 0; t < 40; t++) begin
      ra = W'($urandom); rb = W'($urandom); rcin = 1'($urandom);
      if (t % 8 == 0) rb = ~ra;
      do_op(ra, rb, rcin, int'($urandom_range(0, 2)), rs, rc, ro, cs);
      full = ref_add(ra, rb, rcin);
      chk("rand_sum", 64'(rs), 64'(full[W-1:0]));
      chk("rand_cout", 64'(rc), 64'(full[W]));
      chk("rand_cseq", 64'(cs), 64'(ref_cseq(ra, rb, rcin)));
`ifdef SERIAL_ADD_OVF_EN
      chk("rand_ovf", 64'(ro), 64'(ref_ovf(ra, rb, rcin)));
`endif
    end

    // Back-to-back, NIBBLES=4: out_ready tied high, in_valid held across two pairs
    out_ready = 1'b1;
    @(negedge clk);
    a = 16'h0F0F; b = 16'h00F1; cin = 1'b0; in_valid = 1'b1;
    nacc = 0; nres = 0;
    for (int cyc = 0; cyc < 60 && nres < 2; cyc++) begin
      acc = in_valid && in_ready;
      if (out_valid) begin
        b2b_s[nres] = sum; b2b_c[nres] = cout; nres++;
      end
      if (acc && nacc < 2) begin
        acc_cyc[nacc] = cyc; nacc++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        if (nacc == 1) begin
          a = 16'hF00F; b = 16'h1FF1; cin = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b_counts", {32'(nacc), 32'(nres)}, {32'd2, 32'd2});
    if (nacc == 2 && nres == 2) begin
      chk("b2b_gap", 64'(acc_cyc[1] - acc_cyc[0]), 64'(N + 2));
      full = ref_add(16'h0F0F, 16'h00F1, 1'b0);
      chk("b2b_r0", {b2b_c[0], b2b_s[0]}, 64'(full));
      full = ref_add(16'hF00F, 16'h1FF1, 1'b1);
      chk("b2b_r1", {b2b_c[1], b2b_s[1]}, 64'(full));
    end

    // Back-to-back, NIBBLES=1
    @(negedge clk);
    a1 = 4'hF; b1 = 4'h1; cin1 = 1'b0; in_valid1 = 1'b1;
    nacc = 0; nres = 0;
    for (int cyc = 0; cyc < 30 && nres < 2; cyc++) begin
      acc = in_valid1 && in_ready1;
      if (out_valid1) begin
        b1_s[nres] = sum1; b1_c[nres] = cout1; nres++;
      end
      if (acc && nacc < 2) begin
        acc_cyc[nacc] = cyc; nacc++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        if (nacc == 1) begin
          a1 = 4'h5; b1 = 4'h3; cin1 = 1'b0;
        end else begin
          in_valid1 = 1'b0;
        end
      end
      @(negedge clk);
    end
    in_valid1 = 1'b0;
    chk("n1_counts", {32'(nacc), 32'(nres)}, {32'd2, 32'd2});
    if (nacc == 2 && nres == 2) begin
      chk("n1_gap", 64'(acc_cyc[1] - acc_cyc[0]), 64'd3);
      chk("n1_r0", {b1_c[0], b1_s[0]}, 64'h10);
      chk("n1_r1", {b1_c[1], b1_s[1]}, 64'h08);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
